// File: rtl/tl_bus_arbiter.sv
// Round-robin TileLink-UL arbiter: NUM_MASTERS requesters onto two slaves, one transaction in flight.
// One-cycle arbitration then REQ/RESP pass-through; grant held across A/D stalls, watchdog forces a denied D beat.
module tl_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_MASTERS-1:0]    m_a_valid,
  output logic [NUM_MASTERS-1:0]    m_a_ready,
  input  logic [3*NUM_MASTERS-1:0]  m_a_opcode,
  input  logic [32*NUM_MASTERS-1:0] m_a_address,
  input  logic [32*NUM_MASTERS-1:0] m_a_data,
  input  logic [4*NUM_MASTERS-1:0]  m_a_mask,
  output logic [NUM_MASTERS-1:0]    m_d_valid,
  input  logic [NUM_MASTERS-1:0]    m_d_ready,
  output logic [2:0]                m_d_opcode,
  output logic [31:0]               m_d_data,
  output logic                      m_d_denied,
  output logic [1:0]                s_a_valid,
  input  logic [1:0]                s_a_ready,
  output logic [2:0]                s_a_opcode,
  output logic [31:0]               s_a_address,
  output logic [31:0]               s_a_data,
  output logic [3:0]                s_a_mask,
  input  logic [1:0]                s_d_valid,
  output logic [1:0]                s_d_ready,
  input  logic [5:0]                s_d_opcode,
  input  logic [63:0]               s_d_data,
  input  logic [1:0]                s_d_denied
);

  localparam int          GW = (NUM_MASTERS > 2) ? 2 : 1;
  localparam logic [GW:0] NM = (GW+1)'(NUM_MASTERS);
  localparam logic [15:0] TO = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [31:0] address;
    logic [31:0] data;
    logic [3:0]  mask;
  } a_req_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   rr, rr_nxt, grant, grant_nxt, pick, cand;
  logic            sel, sel_nxt, found, timed_out;
  logic [15:0]     wdog, wdog_nxt;
  a_req_t          a_lat, a_nxt;
  a_req_t          a_in [NUM_MASTERS];
  logic [2:0]      sd_opcode;
  logic [31:0]     sd_data;
  logic            sd_denied;

  function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input logic [GW-1:0] off);
    logic [GW:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= NM) s = s - NM;
    return s[GW-1:0];
  endfunction

  // Slave 1 owns exactly 0x2000..0x3FFF; everything else falls back to slave 0.
  function automatic logic decode_slave(input logic [31:0] addr);
    return (addr[31:14] == '0) && addr[13];
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      a_in[i].opcode  = m_a_opcode[3*i +: 3];
      a_in[i].address = m_a_address[32*i +: 32];
      a_in[i].data    = m_a_data[32*i +: 32];
      a_in[i].mask    = m_a_mask[4*i +: 4];
    end
  end

  always_comb begin
    pick  = rr;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = wrap_add(rr, GW'(k));
      if (!found && m_a_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign sd_opcode = sel ? s_d_opcode[5:3]  : s_d_opcode[2:0];
  assign sd_data   = sel ? s_d_data[63:32]  : s_d_data[31:0];
  assign sd_denied = sel ? s_d_denied[1]    : s_d_denied[0];
  assign timed_out = (wdog >= TO);

  assign s_a_opcode  = a_lat.opcode;
  assign s_a_address = a_lat.address;
  assign s_a_data    = a_lat.data;
  assign s_a_mask    = a_lat.mask;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rr    <= '0;
      grant <= '0;
      sel   <= 1'b0;
      wdog  <= '0;
      a_lat <= '0;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
      grant <= grant_nxt;
      sel   <= sel_nxt;
      wdog  <= wdog_nxt;
      a_lat <= a_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_nxt     = rr;
    grant_nxt  = grant;
    sel_nxt    = sel;
    wdog_nxt   = wdog;
    a_nxt      = a_lat;
    m_a_ready  = '0;
    s_a_valid  = '0;
    m_d_valid  = '0;
    s_d_ready  = '0;
    m_d_opcode = '0;
    m_d_data   = '0;
    m_d_denied = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = pick;
          a_nxt     = a_in[pick];
          sel_nxt   = decode_slave(a_in[pick].address);
          state_nxt = REQ;
        end
      end
      REQ: begin
        s_a_valid[sel]   = 1'b1;
        m_a_ready[grant] = s_a_ready[sel];
        if (s_a_ready[sel]) begin
          rr_nxt    = wrap_add(grant, GW'(1));
          wdog_nxt  = '0;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (timed_out) begin
          // Slave is ignored from here on; the late beat is never acknowledged.
          m_d_valid[grant] = 1'b1;
          m_d_denied       = 1'b1;
          if (m_d_ready[grant]) state_nxt = IDLE;
        end else begin
          m_d_valid[grant] = s_d_valid[sel];
          s_d_ready[sel]   = m_d_ready[grant];
          m_d_opcode       = sd_opcode;
          m_d_data         = sd_data;
          m_d_denied       = sd_denied;
          if (s_d_valid[sel] && m_d_ready[grant]) state_nxt = IDLE;
          else                                    wdog_nxt  = wdog + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tl_bus_arbiter.sv
// Bench for tl_bus_arbiter (2 masters, TIMEOUT=8): decode table, directed corner sequences, random run vs. a transaction model.
module tb_tl_bus_arbiter;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  m_a_valid, m_a_ready, m_d_valid, m_d_ready;
  logic [5:0]  m_a_opcode;
  logic [63:0] m_a_address, m_a_data;
  logic [7:0]  m_a_mask;
  logic [2:0]  m_d_opcode;
  logic [31:0] m_d_data;
  logic        m_d_denied;
  logic [1:0]  s_a_valid, s_a_ready, s_d_valid, s_d_ready, s_d_denied;
  logic [2:0]  s_a_opcode;
  logic [31:0] s_a_address, s_a_data;
  logic [3:0]  s_a_mask;
  logic [5:0]  s_d_opcode;
  logic [63:0] s_d_data;

  int n_chk  = 0;
  int n_pass = 0;
  int sa_pulses = 0;
  int d_beats   = 0;
  logic [1:0] prev_sav = 2'b00;

  tl_bus_arbiter #(.NUM_MASTERS(2), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_opcode(m_a_opcode),
    .m_a_address(m_a_address), .m_a_data(m_a_data), .m_a_mask(m_a_mask),
    .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_opcode(m_d_opcode),
    .m_d_data(m_d_data), .m_d_denied(m_d_denied),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
    .s_a_address(s_a_address), .s_a_data(s_a_data), .s_a_mask(s_a_mask),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
    .s_d_data(s_d_data), .s_d_denied(s_d_denied)
  );

  always #5 clock = ~clock;

  // Counts A-request pulses and delivered D beats, sampled mid-cycle.
  always @(negedge clock) begin
    #2;
    if (s_a_valid != 2'b00 && prev_sav == 2'b00) sa_pulses++;
    prev_sav = s_a_valid;
    if ((m_d_valid & m_d_ready) != 2'b00) d_beats++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clr_inputs();
    m_a_valid = '0; m_a_opcode = '0; m_a_address = '0; m_a_data = '0; m_a_mask = '0;
    m_d_ready = '0; s_a_ready = '0; s_d_valid = '0; s_d_opcode = '0; s_d_data = '0;
    s_d_denied = '0;
  endtask

  task automatic set_m(input int i, input logic [31:0] addr, input logic [2:0] opc,
                       input logic [31:0] dat, input logic [3:0] msk);
    m_a_address[i*32 +: 32] = addr;
    m_a_data[i*32 +: 32]    = dat;
    m_a_opcode[i*3 +: 3]    = opc;
    m_a_mask[i*4 +: 4]      = msk;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    clr_inputs();
    @(negedge clock);
    reset = 1'b1;
  endtask

  function automatic int dec(input logic [31:0] a);
    return (a >= 32'h2000 && a < 32'h4000) ? 1 : 0;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0100;
      1: return 32'h0000_1FFC;
      2: return 32'h0000_2000;
      3: return 32'h0000_3FFC;
      4: return 32'h0000_4000;
      5: return $urandom;
      default: return {18'h0, 14'($urandom)};
    endcase
  endfunction

  typedef struct {
    int          master;
    logic [31:0] addr;
    logic [1:0]  exp_sav;
    logic [31:0] exp_data;
  } vec_t;

  localparam logic [31:0] S0D = 32'h0A0A_0A0A;
  localparam logic [31:0] S1D = 32'h1B1B_1B1B;

  // One complete 0-wait transaction from a single master, checking slave routing.
  task automatic run_vec(input vec_t v);
    logic [1:0] oh;
    oh = 2'b01 << v.master;
    @(negedge clock);
    clr_inputs();
    set_m(v.master, v.addr, 3'd4, 32'h5555_0000 + v.addr, 4'hF);
    m_a_valid = oh;
    s_a_ready = 2'b11;
    #1 chk("vec idle s_a_valid", s_a_valid, 2'b00);
    @(negedge clock);
    #1 chk("vec s_a_valid", s_a_valid, v.exp_sav);
    chk("vec s_a_address", s_a_address, v.addr);
    chk("vec m_a_ready", m_a_ready, oh);
    @(negedge clock);
    m_a_valid = 2'b00;
    s_d_valid = 2'b11;
    m_d_ready = 2'b11;
    s_d_data  = {S1D, S0D};
    #1 chk("vec m_d_valid", m_d_valid, oh);
    chk("vec m_d_data", m_d_data, v.exp_data);
    chk("vec s_d_ready", s_d_ready, v.exp_sav);
    @(negedge clock);
    clr_inputs();
  endtask

  vec_t vt[9];

  // random-run model state
  bit          pend[2];
  logic [31:0] paddr[2], pdata[2];
  logic [3:0]  pmask[2];
  logic [2:0]  popc[2];
  int          rr_m, w, sl, cnt, idx, p0, d0;
  bit          busy, a_done, forced;
  logic [1:0]  e_mar, e_sav, e_mdv, e_sdr;
  logic [31:0] e_dat;
  logic [2:0]  e_opc;
  logic        e_den;

  initial begin
    reset = 1'b0;
    clr_inputs();
    vt[0] = '{0, 32'h0000_0100, 2'b01, S0D};
    vt[1] = '{1, 32'h0000_1FFC, 2'b01, S0D};
    vt[2] = '{0, 32'h0000_2000, 2'b10, S1D};
    vt[3] = '{1, 32'h0000_3FFC, 2'b10, S1D};
    vt[4] = '{0, 32'h0000_4000, 2'b01, S0D};
    vt[5] = '{1, 32'hFFFF_FFFC, 2'b01, S0D};
    vt[6] = '{0, 32'h0000_1FFF, 2'b01, S0D};
    vt[7] = '{1, 32'h0000_3FFF, 2'b10, S1D};
    vt[8] = '{0, 32'h8000_2000, 2'b01, S0D};

    // Reset state
    #2;
    chk("rst s_a_valid", s_a_valid, 2'b00);
    chk("rst m_a_ready", m_a_ready, 2'b00);
    chk("rst m_d_valid", m_d_valid, 2'b00);
    chk("rst s_d_ready", s_d_ready, 2'b00);
    chk("rst s_a_fields", {s_a_opcode, s_a_address, s_a_data, s_a_mask}, 0);
    chk("rst m_d_payload", {m_d_opcode, m_d_data, m_d_denied}, 0);
    @(negedge clock);
    reset = 1'b1;

    // Single read with exact cycle timing
    @(negedge clock);
    set_m(0, 32'h0000_0100, 3'd4, 32'h0, 4'hF);
    m_a_valid = 2'b01;
    s_a_ready = 2'b01;
    #1 chk("rd c0 s_a_valid", s_a_valid, 2'b00);
    chk("rd c0 m_a_ready", m_a_ready, 2'b00);
    @(negedge clock);
    #1 chk("rd c1 s_a_valid", s_a_valid, 2'b01);
    chk("rd c1 m_a_ready", m_a_ready, 2'b01);
    chk("rd c1 s_a_address", s_a_address, 32'h0000_0100);
    chk("rd c1 s_a_opcode", s_a_opcode, 3'd4);
    @(negedge clock);
    m_a_valid = 2'b00;
    s_d_valid = 2'b01;
    s_d_data  = {32'h0, 32'hDEAD_BEEF};
    m_d_ready = 2'b01;
    #1 chk("rd c2 m_d_valid", m_d_valid, 2'b01);
    chk("rd c2 m_d_data", m_d_data, 32'hDEAD_BEEF);
    chk("rd c2 m_d_denied", m_d_denied, 1'b0);
    chk("rd c2 s_d_ready", s_d_ready, 2'b01);
    @(negedge clock);
    clr_inputs();
    #1 chk("rd c3 m_d_valid", m_d_valid, 2'b00);
    chk("rd c3 s_a_valid", s_a_valid, 2'b00);

    // Decode table
    foreach (vt[i]) run_vec(vt[i]);

    // Fairness: both masters continuously requesting, 0-wait slaves
    apply_reset();
    @(negedge clock);
    set_m(0, 32'h0000_0040, 3'd4, 32'h0, 4'hF);
    set_m(1, 32'h0000_2040, 3'd4, 32'h0, 4'hF);
    m_a_valid = 2'b11;
    s_a_ready = 2'b11;
    s_d_valid = 2'b11;
    m_d_ready = 2'b11;
    for (int t = 0; t < 6; t++) begin
      if (t > 0) @(negedge clock);
      #1 chk("fair idle m_a_ready", m_a_ready, 2'b00);
      @(negedge clock);
      #1 chk("fair grant", m_a_ready, (t % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clock);
      #1 chk("fair m_d_valid", m_d_valid, (t % 2 == 0) ? 2'b01 : 2'b10);
    end
    @(negedge clock);
    clr_inputs();

    // Backpressure on A then D
    @(negedge clock);
    set_m(0, 32'h0000_2000, 3'd0, 32'h1234_0000, 4'hF);
    m_a_valid = 2'b01;
    p0 = sa_pulses;
    d0 = d_beats;
    #1 chk("bp idle m_a_ready", m_a_ready, 2'b00);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      #1 chk("bp a-stall s_a_valid", s_a_valid, 2'b10);
      chk("bp a-stall m_a_ready", m_a_ready, 2'b00);
    end
    @(negedge clock);
    s_a_ready = 2'b10;
    #1 chk("bp a-fire m_a_ready", m_a_ready, 2'b01);
    @(negedge clock);
    m_a_valid = 2'b00;
    s_a_ready = 2'b00;
    s_d_valid = 2'b10;
    s_d_data  = {32'hCAFE_0001, 32'h0};
    #1 chk("bp d-stall m_d_valid", m_d_valid, 2'b01);
    chk("bp d-stall s_d_ready", s_d_ready, 2'b00);
    chk("bp d-stall s_a_valid", s_a_valid, 2'b00);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      #1 chk("bp d-stall held", m_d_valid, 2'b01);
    end
    @(negedge clock);
    m_d_ready = 2'b01;
    #1 chk("bp d-fire s_d_ready", s_d_ready, 2'b10);
    chk("bp d-fire data", m_d_data, 32'hCAFE_0001);
    @(negedge clock);
    clr_inputs();
    #1 chk("bp after m_d_valid", m_d_valid, 2'b00);
    @(negedge clock);
    @(negedge clock);
    #3 chk("bp a pulses", sa_pulses - p0, 1);
    chk("bp d beats", d_beats - d0, 1);

    // Watchdog: slave 0 never answers in time
    @(negedge clock);
    clr_inputs();
    set_m(1, 32'h0000_0100, 3'd4, 32'h0, 4'hF);
    m_a_valid = 2'b10;
    s_a_ready = 2'b01;
    #1;
    @(negedge clock);
    #1 chk("wd a-fire m_a_ready", m_a_ready, 2'b10);
    @(negedge clock);
    clr_inputs();
    #1 chk("wd resp1 m_d_valid", m_d_valid, 2'b00);
    for (int k = 2; k <= TO; k++) begin
      @(negedge clock);
      #1 chk("wd waiting m_d_valid", m_d_valid, 2'b00);
    end
    @(negedge clock);
    s_d_valid  = 2'b01;
    s_d_data   = {32'h0, 32'h1234_5678};
    s_d_opcode = 6'b000_001;
    #1 chk("wd forced m_d_valid", m_d_valid, 2'b10);
    chk("wd forced denied", m_d_denied, 1'b1);
    chk("wd forced data", m_d_data, 32'h0);
    chk("wd forced opcode", m_d_opcode, 3'd0);
    chk("wd forced s_d_ready", s_d_ready, 2'b00);
    @(negedge clock);
    #1 chk("wd forced held", m_d_valid, 2'b10);
    @(negedge clock);
    m_d_ready = 2'b10;
    #1 chk("wd handshake m_d_valid", m_d_valid, 2'b10);
    chk("wd handshake s_d_ready", s_d_ready, 2'b00);
    @(negedge clock);
    clr_inputs();
    #1 chk("wd idle m_d_valid", m_d_valid, 2'b00);
    chk("wd idle s_a_valid", s_a_valid, 2'b00);

    // Async reset mid-RESP, then rr restarts at master 0
    @(negedge clock);
    set_m(0, 32'h0000_0100, 3'd4, 32'h0, 4'hF);
    m_a_valid = 2'b01;
    s_a_ready = 2'b01;
    #1;
    @(negedge clock);
    #1 chk("ar a-fire m_a_ready", m_a_ready, 2'b01);
    @(negedge clock);
    m_a_valid = 2'b00;
    s_a_ready = 2'b00;
    s_d_valid = 2'b01;
    m_d_ready = 2'b01;
    #1 chk("ar pre m_d_valid", m_d_valid, 2'b01);
    chk("ar pre s_d_ready", s_d_ready, 2'b01);
    #2 reset = 1'b0;
    #1 chk("ar m_d_valid", m_d_valid, 2'b00);
    chk("ar s_d_ready", s_d_ready, 2'b00);
    chk("ar s_a_valid", s_a_valid, 2'b00);
    chk("ar m_a_ready", m_a_ready, 2'b00);
    @(negedge clock);
    clr_inputs();
    reset = 1'b1;
    set_m(0, 32'h0000_0200, 3'd4, 32'h0, 4'hF);
    set_m(1, 32'h0000_2200, 3'd4, 32'h0, 4'hF);
    m_a_valid = 2'b11;
    s_a_ready = 2'b11;
    #1 chk("ar idle m_a_ready", m_a_ready, 2'b00);
    @(negedge clock);
    #1 chk("ar first grant", m_a_ready, 2'b01);
    @(negedge clock);
    m_a_valid = 2'b10;
    s_d_valid = 2'b11;
    m_d_ready = 2'b11;
    #1 chk("ar first resp", m_d_valid, 2'b01);
    @(negedge clock);
    #1 chk("ar idle2 m_a_ready", m_a_ready, 2'b00);
    @(negedge clock);
    #1 chk("ar second grant", m_a_ready, 2'b10);
    @(negedge clock);
    m_a_valid = 2'b00;
    @(negedge clock);
    clr_inputs();

    // Randomized run against transaction model
    apply_reset();
    rr_m = 0; busy = 0; a_done = 0; cnt = 0; w = 0; sl = 0;
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]  = 1;
          paddr[i] = rand_addr();
          pdata[i] = $urandom;
          pmask[i] = 4'($urandom);
          popc[i]  = 3'($urandom_range(0, 4));
        end
        m_a_valid[i] = pend[i];
        set_m(i, paddr[i], popc[i], pdata[i], pmask[i]);
      end
      s_a_ready    = 2'($urandom);
      s_d_valid[0] = ($urandom_range(0, 3) == 0);
      s_d_valid[1] = ($urandom_range(0, 3) == 0);
      m_d_ready    = 2'($urandom);
      s_d_data     = {$urandom, $urandom};
      s_d_opcode   = 6'($urandom);
      s_d_denied   = 2'($urandom);
      #1;
      e_mar = '0; e_sav = '0; e_mdv = '0; e_sdr = '0; e_dat = '0; e_opc = '0; e_den = 1'b0;
      forced = busy && a_done && (cnt >= TO);
      if (busy && !a_done) begin
        e_sav[sl] = 1'b1;
        e_mar[w]  = s_a_ready[sl];
      end else if (forced) begin
        e_mdv[w] = 1'b1;
        e_den    = 1'b1;
      end else if (busy) begin
        e_mdv[w]  = s_d_valid[sl];
        e_sdr[sl] = m_d_ready[w];
        e_dat     = s_d_data[sl*32 +: 32];
        e_opc     = s_d_opcode[sl*3 +: 3];
        e_den     = s_d_denied[sl];
      end
      chk("rnd m_a_ready", m_a_ready, e_mar);
      chk("rnd s_a_valid", s_a_valid, e_sav);
      chk("rnd m_d_valid", m_d_valid, e_mdv);
      chk("rnd s_d_ready", s_d_ready, e_sdr);
      if (e_mdv != 2'b00) chk("rnd d payload", {m_d_opcode, m_d_denied, m_d_data}, {e_opc, e_den, e_dat});
      if (busy && !a_done) begin
        chk("rnd s_a addr/data", {s_a_address, s_a_data}, {paddr[w], pdata[w]});
        chk("rnd s_a opc/mask", {s_a_opcode, s_a_mask}, {popc[w], pmask[w]});
      end
      // advance the model across the coming edge
      if (!busy) begin
        for (int k = 0; k < 2; k++) begin
          idx = (rr_m + k) % 2;
          if (!busy && pend[idx]) begin
            busy = 1; w = idx; a_done = 0; sl = dec(paddr[idx]);
          end
        end
      end else if (!a_done) begin
        if (s_a_ready[sl]) begin
          a_done = 1; cnt = 0; rr_m = (w + 1) % 2; pend[w] = 0;
        end
      end else if (forced) begin
        if (m_d_ready[w]) busy = 0;
      end else if (s_d_valid[sl] && m_d_ready[w]) begin
        busy = 0;
      end else begin
        cnt++;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tl_bus_arbiter.md
Name: tl_bus_arbiter

Overview:
- Shares the TileLink-UL system bus between NUM_MASTERS requesters (e.g. I-cache, D-cache) and two slave ports.
- Slave 0 covers 0x0000_0000–0x0000_1FFF; slave 1 covers 0x0000_2000–0x0000_3FFF; any other address routes to slave 0.
- Round-robin grant, with at most one transaction outstanding on the bus.
- The grant is held until the D response completes.
- A watchdog returns a denied response if a slave hangs.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..4).
- TIMEOUT, 255, maximum cycles in RESP before an error response is forced (1..65535).

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- m_a_valid  input  NUM_MASTERS  per-master A-channel valid.
- m_a_ready  output  NUM_MASTERS  per-master A-channel ready.
- m_a_opcode  input  3*NUM_MASTERS  A opcode, master i at bits [3i+2:3i].
- m_a_address  input  32*NUM_MASTERS  A address, packed the same way.
- m_a_data  input  32*NUM_MASTERS  A write data.
- m_a_mask  input  4*NUM_MASTERS  A byte mask.
- m_d_valid  output  NUM_MASTERS  per-master D valid.
- m_d_ready  input  NUM_MASTERS  per-master D ready.
- m_d_opcode  output  3  D opcode, broadcast to all masters.
- m_d_data  output  32  D read data, broadcast.
- m_d_denied  output  1  D error flag, broadcast.
- s_a_valid  output  2  per-slave A valid.
- s_a_ready  input  2  per-slave A ready.
- s_a_opcode  output  3  latched A opcode to the slaves.
- s_a_address  output  32  latched A address.
- s_a_data  output  32  latched A write data.
- s_a_mask  output  4  latched A byte mask.
- s_d_valid  input  2  per-slave D valid.
- s_d_ready  output  2  per-slave D ready.
- s_d_opcode  input  3*2  per-slave D opcode.
- s_d_data  input  32*2  per-slave D data.
- s_d_denied  input  2  per-slave D error flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE, the round-robin pointer rr to 0, grant to 0, sel to 0, and the watchdog counter to 0.
  - All valid and ready outputs are 0.
  - The latched A fields and the D payload outputs are 0.
- IDLE:
  - If any m_a_valid is set, grant the first requester at or after rr in circular order.
  - At the clock edge, latch grant, that master's A fields, and sel, the decoded slave index.
  - Next state is REQ. All m_a_ready are 0 in IDLE.
  - Arbitration costs exactly one cycle.
- REQ:
  - s_a_valid[sel]=1; the other s_a_valid bit is 0.
  - m_a_ready[grant] = s_a_ready[sel]; other masters see m_a_ready=0.
  - On fire (s_a_ready[sel]=1): set rr = (grant+1) mod NUM_MASTERS, clear the watchdog, go to RESP.
  - The master must hold its A fields stable until m_a_ready. The block forwards the latched copy.
- RESP:
  - m_d_valid[grant] = s_d_valid[sel]; m_d_opcode, m_d_data and m_d_denied come from slave sel.
  - s_d_ready[sel] = m_d_ready[grant]; the other s_d_ready bit is 0.
  - On D fire, go to IDLE.
  - The watchdog increments each cycle with no D fire.
  - When the watchdog reaches TIMEOUT, the block takes over the response:
    - It drives m_d_valid[grant]=1, m_d_denied=1, m_d_data=0, m_d_opcode=AccessAck (0).
    - It forces s_d_ready[sel]=0 and holds this until m_d_ready[grant], then goes to IDLE.
    - A late slave response is not forwarded.
- Same-cycle events:
  - Simultaneous requests: only the granted master advances; the others wait with ready=0.
  - A request arriving in the same cycle D fires is seen in the following IDLE cycle.
- Address decode:
  - addr < 0x2000 selects slave 0.
  - 0x2000 ≤ addr < 0x4000 selects slave 1.
  - Any other address selects slave 0.
- Reset during REQ or RESP aborts the transaction immediately: all valids drop asynchronously. No response is owed.
- Throughput: at best one transaction every 3 cycles (IDLE, REQ, RESP), with 0-wait slaves.

Test Plan:
- Single read:
  - Stimulus: master 0 requests address 0x0000_0100; slave 0 has s_a_ready=1 and returns data 0xDEADBEEF one cycle after A fire.
  - Required response: s_a_valid=01 on cycle 1; m_d_valid[0] on cycle 2 with m_d_data=0xDEADBEEF; back to IDLE on cycle 3.
- Decode boundaries:
  - Stimulus: addresses 0x1FFC, 0x2000, 0x3FFC and 0x4000.
  - Required response: s_a_valid = 01, 10, 10 and 01 respectively.
- Fairness:
  - Stimulus: both masters hold valid continuously for 6 transactions.
  - Required response: grant order 0,1,0,1,0,1; the losing master sees m_a_ready=0 throughout.
- Backpressure:
  - Stimulus: s_a_ready held low 4 cycles, then m_d_ready held low 3 cycles.
  - Required response: the grant is held, no second s_a_valid pulse, and exactly one D beat is delivered.
- Watchdog:
  - Stimulus: TIMEOUT=8 and the slave never asserts d_valid.
  - Required response: 8 cycles after A fire, m_d_valid[grant]=1 with m_d_denied=1 and m_d_data=0; IDLE after the handshake.
- Async reset:
  - Stimulus: assert reset mid-RESP, away from any clock edge.
  - Required response: all valids and readies go to 0 immediately; after release, a new request from master 1 is granted first only if rr=0 finds master 0 idle.
